// File: rtl/pkt_tx_serializer_pkg.sv
// Shared packet definitions for the TX serializer and the RX field parser.
// Provides packet-type and FSM-state enums, word-index constants, the
// captured-field struct and the per-type data-word count.
package pkt_tx_serializer_pkg;

    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned TS_WIDTH   = 6;
    localparam int unsigned DROP_WIDTH = 8;
    localparam int unsigned TYPE_WIDTH = 3;
    localparam int unsigned HDR_PAD    = 7;
    localparam int unsigned IDX_WIDTH  = 3;
    localparam int unsigned LEN_WIDTH  = 4;

    typedef enum logic [TYPE_WIDTH-1:0] {
        PT_HB      = 3'b000,
        PT_CH_ADV  = 3'b001,
        PT_CH_JOIN = 3'b010,
        PT_DATA_3  = 3'b011,
        PT_DATA_4  = 3'b100,
        PT_DATA_5  = 3'b101,
        PT_DATA_6  = 3'b110,
        PT_INVALID = 3'b111
    } pkt_type_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SEND  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4
    } tx_state_t;

    localparam logic [IDX_WIDTH-1:0] IDX_HDR      = 3'd0;
    localparam logic [IDX_WIDTH-1:0] IDX_SRC      = 3'd1;
    localparam logic [IDX_WIDTH-1:0] IDX_SRC_HOPS = 3'd2;
    localparam logic [IDX_WIDTH-1:0] IDX_Q        = 3'd3;
    localparam logic [IDX_WIDTH-1:0] IDX_ENERGY   = 3'd4;
    localparam logic [IDX_WIDTH-1:0] IDX_CH       = 3'd5;
    localparam logic [IDX_WIDTH-1:0] IDX_HOPS_CH  = 3'd6;
    localparam logic [IDX_WIDTH-1:0] IDX_DEST     = 3'd7;

    typedef struct packed {
        pkt_type_t             pktType;
        logic [TS_WIDTH-1:0]   timeslot;
        logic [WORD_WIDTH-1:0] sourceId;
        logic [WORD_WIDTH-1:0] destinationId;
        logic [WORD_WIDTH-1:0] sourceHops;
        logic [WORD_WIDTH-1:0] qValue;
        logic [WORD_WIDTH-1:0] energyLeft;
        logic [WORD_WIDTH-1:0] chosenCh;
        logic [WORD_WIDTH-1:0] hopsFromCh;
    } pkt_fields_t;

    // Data words carried by a packet of the given type (checksum excluded).
    function automatic logic [LEN_WIDTH-1:0] pkt_len(input pkt_type_t t);
        case (t)
            PT_HB:                 return 4'd5;
            PT_CH_ADV, PT_CH_JOIN: return 4'd7;
            default:               return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/pkt_tx_serializer_if.sv
// TX word stream: txWord/txValid/txLast from the serializer, txReady from the sink.
interface pkt_tx_serializer_if;
    import pkt_tx_serializer_pkg::*;

    logic [WORD_WIDTH-1:0] txWord;
    logic                  txValid;
    logic                  txReady;
    logic                  txLast;

    modport master (output txWord, txValid, txLast, input txReady);
    modport slave  (input txWord, txValid, txLast, output txReady);
endinterface

// File: rtl/pkt_tx_serializer_tx_word_mux.sv
// Combinational packet word selector.
// Ports: idx (word index), fields (captured packet) -> word_c (packet word).
module tx_word_mux
    import pkt_tx_serializer_pkg::*;
(
    input  logic [IDX_WIDTH-1:0]  idx,
    input  pkt_fields_t           fields,
    output logic [WORD_WIDTH-1:0] word_c
);

    always_comb begin
        word_c = '0;
        case (idx)
            IDX_HDR:      word_c = {fields.pktType, fields.timeslot, HDR_PAD'(0)};
            IDX_SRC:      word_c = fields.sourceId;
            IDX_SRC_HOPS: word_c = fields.sourceHops;
            IDX_Q:        word_c = fields.qValue;
            IDX_ENERGY:   word_c = fields.energyLeft;
            IDX_CH:       word_c = fields.chosenCh;
            IDX_HOPS_CH:  word_c = fields.hopsFromCh;
            IDX_DEST:     word_c = fields.destinationId;
            default:      word_c = '0;
        endcase
    end

endmodule

// File: rtl/pkt_tx_serializer.sv
// Packet TX serializer: captures r* fields on load, waits in ARMED for the
// TX slot (okToSend), streams the packet as 16-bit words plus an XOR
// checksum word over txBus, then pulses txDone.
// Ports: clk, nrst (sync active-low), load, okToSend, r* packet fields,
//        txBus (master: txWord/txValid/txLast out, txReady in),
//        busy, txDone, dropCount (saturating reject/expiry count).
module pkt_tx_serializer
    import pkt_tx_serializer_pkg::*;
#(
    parameter int unsigned ARM_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    load,
    input  logic                    okToSend,
    input  logic [TYPE_WIDTH-1:0]   rPacketType,
    input  logic [WORD_WIDTH-1:0]   rSourceID,
    input  logic [WORD_WIDTH-1:0]   rDestinationID,
    input  logic [WORD_WIDTH-1:0]   rSourceHops,
    input  logic [WORD_WIDTH-1:0]   rQValue,
    input  logic [WORD_WIDTH-1:0]   rEnergyLeft,
    input  logic [WORD_WIDTH-1:0]   rChosenCH,
    input  logic [WORD_WIDTH-1:0]   rHopsFromCH,
    input  logic [TS_WIDTH-1:0]     rTimeslot,
    pkt_tx_serializer_if.master     txBus,
    output logic                    busy,
    output logic                    txDone,
    output logic [DROP_WIDTH-1:0]   dropCount
);

    localparam int unsigned CNT_W = $clog2(ARM_TIMEOUT + 1);
    localparam int unsigned SUM_W = DROP_WIDTH + 2;

    tx_state_t             state;
    pkt_fields_t           fields;
    logic [IDX_WIDTH-1:0]  idx;
    logic [WORD_WIDTH-1:0] cksum;
    logic [CNT_W-1:0]      armCnt;
    logic [WORD_WIDTH-1:0] txWordQ;
    logic                  txValidQ;
    logic                  txLastQ;

    logic                  handshake_c;
    logic                  lastData_c;
    logic                  loadDrop_c;
    logic                  timeoutDrop_c;
    logic [SUM_W-1:0]      dropSum_c;
    logic [DROP_WIDTH-1:0] dropNext_c;
    logic [IDX_WIDTH-1:0]  muxIdx_c;
    logic [WORD_WIDTH-1:0] muxWord_c;

    assign txBus.txWord  = txWordQ;
    assign txBus.txValid = txValidQ;
    assign txBus.txLast  = txLastQ;

    assign handshake_c = txValidQ && txBus.txReady;
    assign lastData_c  = ({1'b0, idx} == (pkt_len(fields.pktType) - LEN_WIDTH'(1)));

    // Any load outside IDLE, or an invalid-type load in IDLE, is rejected.
    assign loadDrop_c    = load && ((state != ST_IDLE) || (pkt_type_t'(rPacketType) == PT_INVALID));
    // Pending okToSend on the expiry edge takes priority over discarding.
    assign timeoutDrop_c = (state == ST_ARMED) && !okToSend &&
                           (armCnt == CNT_W'(ARM_TIMEOUT - 1));

    // Both drop sources can coincide, so add both and saturate.
    assign dropSum_c  = SUM_W'(dropCount) + SUM_W'(loadDrop_c) + SUM_W'(timeoutDrop_c);
    assign dropNext_c = (dropSum_c > SUM_W'({DROP_WIDTH{1'b1}})) ? '1 : dropSum_c[DROP_WIDTH-1:0];

    // Pre-select the word that becomes visible after the next transfer.
    assign muxIdx_c = (state == ST_SEND) ? (idx + IDX_WIDTH'(1)) : IDX_HDR;

    tx_word_mux u_tx_word_mux (
        .idx    (muxIdx_c),
        .fields (fields),
        .word_c (muxWord_c)
    );

    // FSM, counters, checksum and registered outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            fields    <= '0;
            idx       <= '0;
            cksum     <= '0;
            armCnt    <= '0;
            txWordQ   <= '0;
            txValidQ  <= 1'b0;
            txLastQ   <= 1'b0;
            busy      <= 1'b0;
            txDone    <= 1'b0;
            dropCount <= '0;
        end else begin
            dropCount <= dropNext_c;
            txDone    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load && (pkt_type_t'(rPacketType) != PT_INVALID)) begin
                        fields <= '{pktType:       pkt_type_t'(rPacketType),
                                    timeslot:      rTimeslot,
                                    sourceId:      rSourceID,
                                    destinationId: rDestinationID,
                                    sourceHops:    rSourceHops,
                                    qValue:        rQValue,
                                    energyLeft:    rEnergyLeft,
                                    chosenCh:      rChosenCH,
                                    hopsFromCh:    rHopsFromCH};
                        armCnt <= '0;
                        busy   <= 1'b1;
                        state  <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (okToSend) begin
                        txWordQ  <= muxWord_c;
                        txValidQ <= 1'b1;
                        state    <= ST_SEND;
                    end else if (timeoutDrop_c) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        armCnt <= armCnt + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (handshake_c) begin
                        cksum <= cksum ^ txWordQ;
                        if (lastData_c) begin
                            txWordQ <= cksum ^ txWordQ;
                            txLastQ <= 1'b1;
                            state   <= ST_CKSUM;
                        end else begin
                            txWordQ <= muxWord_c;
                            idx     <= idx + IDX_WIDTH'(1);
                        end
                    end
                end
                ST_CKSUM: begin
                    if (handshake_c) begin
                        txWordQ  <= '0;
                        txValidQ <= 1'b0;
                        txLastQ  <= 1'b0;
                        txDone   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    idx   <= '0;
                    cksum <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
